// File: rtl/sharkpsg_voice_bank_if.sv
// Register-write bus and stereo sample output of the PSG voice bank.
// The control path drives it as master; the voice bank is the slave.
interface sharkpsg_voice_bank_if #(
  parameter int NUM_VOICES = 8,
  parameter int MIX_W      = 12
);
  localparam int AW = $clog2(NUM_VOICES) + 2;

  logic                    wr_en;
  logic [AW-1:0]           wr_addr;
  logic [15:0]             wr_data;
  logic signed [MIX_W-1:0] mix_l;
  logic signed [MIX_W-1:0] mix_r;
  logic                    sample_valid;

  modport master (
    output wr_en, wr_addr, wr_data,
    input  mix_l, mix_r, sample_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    output mix_l, mix_r, sample_valid
  );
endinterface

// File: rtl/sharkpsg_voice_bank.sv
// Time-multiplexed PSG voice bank: one shared datapath visits each voice once per
// sample frame, sums a stereo mix and emits one saturated sample per frame.
module sharkpsg_voice_bank #(
  parameter int NUM_VOICES = 8,
  parameter int PITCH_W    = 8,
  parameter int MIX_W      = 12,
  parameter int SAMPLE_DIV = 256
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  ena,
  sharkpsg_voice_bank_if.slave bus
);
  localparam int AW       = $clog2(NUM_VOICES) + 2;
  localparam int VI_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W    = $clog2(SAMPLE_DIV);
  localparam int ACC_NEED = $clog2(NUM_VOICES * 225 + 1) + 1;
  localparam int ACC_W    = (ACC_NEED > MIX_W + 1) ? ACC_NEED : MIX_W + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (MIX_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic [CNT_W-1:0]        r_cnt;
  logic [PITCH_W-1:0]      r_pitch [NUM_VOICES];
  logic [2:0]              r_oct   [NUM_VOICES];
  logic [1:0]              r_pan   [NUM_VOICES];
  logic [1:0]              r_wave  [NUM_VOICES];
  logic [3:0]              r_vol   [NUM_VOICES];
  logic [15:0]             r_phase [NUM_VOICES];
  logic [14:0]             r_lfsr  [NUM_VOICES];
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
  logic signed [MIX_W-1:0] r_mix_l, r_mix_r;
  logic                    r_valid;

  logic                    w_accum, w_output, w_carry, w_unused_data;
  logic [VI_W-1:0]         w_vidx;
  logic [AW-1:0]           w_wr_voice;
  logic [23:0]             w_inc, w_sum;
  logic signed [4:0]       w_w;
  logic signed [9:0]       w_c;
  logic signed [MIX_W-1:0] w_sat_l, w_sat_r;

  assign w_accum       = r_cnt < CNT_W'(NUM_VOICES);
  assign w_output      = r_cnt == CNT_W'(NUM_VOICES);
  assign w_vidx        = r_cnt[VI_W-1:0];
  assign w_wr_voice    = bus.wr_addr >> 2;
  assign w_unused_data = &{1'b0, bus.wr_data};

  // Shared datapath: operands come from the voice selected by the frame counter.
  assign w_inc   = 24'(r_pitch[w_vidx]) << r_oct[w_vidx];
  assign w_sum   = {8'd0, r_phase[w_vidx]} + w_inc;
  assign w_carry = |w_sum[23:16];

  always_comb begin
    w_w = '0;
    case (r_wave[w_vidx])
      2'd0:    w_w = r_phase[w_vidx][15] ? 5'sd15 : -5'sd15;
      2'd1:    w_w = $signed({r_phase[w_vidx][15:12], 1'b0} - 5'd15);
      2'd2:    w_w = r_lfsr[w_vidx][0] ? 5'sd15 : -5'sd15;
      default: w_w = '0;
    endcase
  end

  assign w_c = 10'(w_w) * 10'($signed({1'b0, r_vol[w_vidx]}));

  assign w_sat_l = (r_acc_l > SAT_MAX) ? SAT_MAX[MIX_W-1:0] :
                   (r_acc_l < SAT_MIN) ? SAT_MIN[MIX_W-1:0] : r_acc_l[MIX_W-1:0];
  assign w_sat_r = (r_acc_r > SAT_MAX) ? SAT_MAX[MIX_W-1:0] :
                   (r_acc_r < SAT_MIN) ? SAT_MIN[MIX_W-1:0] : r_acc_r[MIX_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (ena) begin
      r_cnt <= (r_cnt == CNT_W'(SAMPLE_DIV - 1)) ? '0 : r_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      logic w_hit;
      assign w_hit = bus.wr_en && (w_wr_voice == AW'(gi));

      // A restart write beats the same-cycle phase/LFSR step of this voice.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pitch[gi] <= '0;
          r_oct[gi]   <= '0;
          r_pan[gi]   <= '0;
          r_wave[gi]  <= '0;
          r_vol[gi]   <= '0;
          r_phase[gi] <= '0;
          r_lfsr[gi]  <= 15'h0001;
        end else begin
          if (w_hit && bus.wr_addr[1:0] == 2'd0) r_pitch[gi] <= bus.wr_data[PITCH_W-1:0];
          if (w_hit && bus.wr_addr[1:0] == 2'd1) begin
            r_oct[gi]  <= bus.wr_data[6:4];
            r_pan[gi]  <= bus.wr_data[3:2];
            r_wave[gi] <= bus.wr_data[1:0];
          end
          if (w_hit && bus.wr_addr[1:0] == 2'd2) r_vol[gi] <= bus.wr_data[3:0];
          if (w_hit && bus.wr_addr[1:0] == 2'd3) begin
            r_phase[gi] <= '0;
            r_lfsr[gi]  <= 15'h0001;
          end else if (ena && w_accum && w_vidx == VI_W'(gi)) begin
            r_phase[gi] <= w_sum[15:0];
            if (w_carry) r_lfsr[gi] <= {r_lfsr[gi][13:0], r_lfsr[gi][14] ^ r_lfsr[gi][13]};
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
      r_mix_l <= '0;
      r_mix_r <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (ena && w_accum) begin
        if (r_pan[w_vidx][0]) r_acc_l <= r_acc_l + ACC_W'(w_c);
        if (r_pan[w_vidx][1]) r_acc_r <= r_acc_r + ACC_W'(w_c);
      end else if (ena && w_output) begin
        r_mix_l <= w_sat_l;
        r_mix_r <= w_sat_r;
        r_valid <= 1'b1;
        r_acc_l <= '0;
        r_acc_r <= '0;
      end
    end
  end

  assign bus.mix_l        = r_mix_l;
  assign bus.mix_r        = r_mix_r;
  assign bus.sample_valid = r_valid;
endmodule

// File: tb/tb_sharkpsg_voice_bank.sv
// Directed bench for sharkpsg_voice_bank: short frames (SAMPLE_DIV=16), MIX_W=10.
module tb_sharkpsg_voice_bank;
  localparam int NV = 8;
  localparam int PW = 8;
  localparam int MW = 10;
  localparam int SD = 16;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  sharkpsg_voice_bank_if #(.NUM_VOICES(NV), .MIX_W(MW)) bus ();

  sharkpsg_voice_bank #(
    .NUM_VOICES(NV), .PITCH_W(PW), .MIX_W(MW), .SAMPLE_DIV(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ena(ena),
    .bus(bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    ena         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wr(input int addr, input int data);
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr[4:0];
    bus.wr_data = data[15:0];
    @(posedge clk);
    #1 bus.wr_en = 1'b0;
  endtask

  // Waits (bounded) for the next sample pulse; reports negedges waited.
  task automatic wait_sample(output int l, output int r, output int cyc);
    bit got;
    got = 1'b0;
    l   = 0;
    r   = 0;
    cyc = 0;
    while (!got && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.sample_valid) begin
        got = 1'b1;
        l   = $signed(bus.mix_l);
        r   = $signed(bus.mix_r);
      end
    end
    if (!got) chk("sample_timeout", cyc, -1);
  endtask

  initial begin
    int l, r, cyc, expv, ph, lf, sum, held_l, frozen_bad;
    time t19, t20;

    // Idle bank: reset values, first-sample latency, silent frames
    do_reset();
    @(negedge clk);
    chk("rst_mix_l", $signed(bus.mix_l), 0);
    chk("rst_mix_r", $signed(bus.mix_r), 0);
    chk("rst_valid", int'(bus.sample_valid), 0);
    @(posedge clk);
    #1 ena = 1'b1;
    wait_sample(l, r, cyc);
    chk("t1_latency", cyc, NV + 2);
    chk("t1_l0", l, 0);
    chk("t1_r0", r, 0);
    wait_sample(l, r, cyc);
    chk("t1_period", cyc, SD);
    chk("t1_l1", l, 0);

    // Square on voice 0, vol 15, both channels
    do_reset();
    wr(0, 'h80);
    wr(1, 'h0C);
    wr(2, 15);
    ena = 1'b1;
    for (int k = 0; k <= 512; k++) begin
      wait_sample(l, r, cyc);
      if (k == 0 || k == 255 || k == 256 || k == 511 || k == 512) begin
        expv = ((k % 512) < 256) ? -225 : 225;
        chk($sformatf("t2_l_f%0d", k), l, expv);
        chk($sformatf("t2_r_f%0d", k), r, expv);
      end
    end

    // Saw on voice 1, octave 4, vol 1, left only
    do_reset();
    wr(4, 'h10);
    wr(5, 'h45);
    wr(6, 1);
    ena = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      wait_sample(l, r, cyc);
      if (k == 0 || k == 15 || k == 16 || k == 128 || k == 240 || k == 256) begin
        expv = 2 * ((k % 256) / 16) - 15;
        chk($sformatf("t3_l_f%0d", k), l, expv);
        chk($sformatf("t3_r_f%0d", k), r, 0);
      end
    end

    // All voices square at full volume: saturation to the 10-bit range
    do_reset();
    for (int v = 0; v < NV; v++) begin
      wr(v * 4, 'h80);
      wr(v * 4 + 1, 'h0C);
      wr(v * 4 + 2, 15);
    end
    ena = 1'b1;
    for (int k = 0; k <= 256; k++) begin
      wait_sample(l, r, cyc);
      if (k == 0 || k == 255) begin
        chk($sformatf("t4_l_f%0d", k), l, -512);
        chk($sformatf("t4_r_f%0d", k), r, -512);
      end else if (k == 256) begin
        chk("t4_l_f256", l, 511);
        chk("t4_r_f256", r, 511);
      end
    end

    // Reset in the middle of a frame discards the partial mix
    repeat (4) @(posedge clk);
    do_reset();
    @(negedge clk);
    chk("t4_midrst_l", $signed(bus.mix_l), 0);
    chk("t4_midrst_valid", int'(bus.sample_valid), 0);
    @(posedge clk);
    #1 ena = 1'b1;
    wait_sample(l, r, cyc);
    chk("t4_midrst_lat", cyc, NV + 2);
    chk("t4_midrst_l0", l, 0);

    // Noise on voice 2 against a reference LFSR, then a restart during its ACCUM slot
    do_reset();
    wr(8, 'hFF);
    wr(9, 'h7E);
    wr(10, 2);
    ena = 1'b1;
    ph = 0;
    lf = 1;
    for (int k = 0; k < 21; k++) begin
      if (k == 20) begin
        // cnt is NV+1 here; the 10th edge from now samples cnt==2
        repeat (9) @(posedge clk);
        #1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd11;
        bus.wr_data = 16'h1234;
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
      end
      wait_sample(l, r, cyc);
      expv = (lf & 1) ? 30 : -30;
      chk($sformatf("t5_l_f%0d", k), l, expv);
      chk($sformatf("t5_r_f%0d", k), r, expv);
      sum = ph + 'h7F80;
      if (sum > 'hFFFF) lf = ((lf << 1) & 'h7FFF) | (((lf >> 14) ^ (lf >> 13)) & 1);
      ph = sum & 'hFFFF;
    end
    ph = 0;
    lf = 1;
    for (int k = 21; k < 30; k++) begin
      wait_sample(l, r, cyc);
      expv = (lf & 1) ? 30 : -30;
      chk($sformatf("t5_rs_l_f%0d", k), l, expv);
      sum = ph + 'h7F80;
      if (sum > 'hFFFF) lf = ((lf << 1) & 'h7FFF) | (((lf >> 14) ^ (lf >> 13)) & 1);
      ph = sum & 'hFFFF;
    end

    // Freeze for 100 cycles in the middle of the ACCUM phase
    do_reset();
    wr(4, 'h10);
    wr(5, 'h45);
    wr(6, 1);
    ena = 1'b1;
    t19 = 0;
    for (int k = 0; k < 20; k++) begin
      wait_sample(l, r, cyc);
      t19 = $time;
    end
    chk("t6_l_f19", l, 2 * (19 / 16) - 15);
    repeat (9) @(posedge clk);
    #1 ena = 1'b0;
    held_l     = $signed(bus.mix_l);
    frozen_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.sample_valid || $signed(bus.mix_l) != held_l) frozen_bad++;
      @(posedge clk);
    end
    #1 ena = 1'b1;
    chk("t6_frozen_events", frozen_bad, 0);
    chk("t6_hold_l", held_l, -13);
    wait_sample(l, r, cyc);
    t20 = $time;
    chk("t6_gap_cycles", int'((t20 - t19) / 10), SD + 100);
    chk("t6_l_f20", l, 2 * (20 / 16) - 15);
    for (int k = 21; k <= 40; k++) begin
      wait_sample(l, r, cyc);
      if (k == 31 || k == 32 || k == 40) begin
        chk($sformatf("t6_l_f%0d", k), l, 2 * (k / 16) - 15);
        chk($sformatf("t6_period_f%0d", k), cyc, SD);
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
